// File: rtl/esm_hazard_checker.sv
// esm_hazard_checker
//   Monitors the ESM scheduler's instruction stream. Each cycle one word is
//   accepted and forwarded with one cycle of latency. The checker flags
//   read-after-write dependencies on writers issued within the last DEPTH
//   cycles. It also keeps saturating issue, bubble and hazard counters.
//
// Parameters
//   Instruction_word_size : instruction width; only 32 is meaningful, because
//                           the RV32I field positions are fixed.
//   DEPTH                 : result-availability distance in cycles (1..15).
//
// Ports
//   clk          : clock; all state updates on the rising edge
//   rst          : synchronous active-high reset
//   Instr_in     : instruction word; all-zero means bubble
//   Instr_out    : Instr_in delayed by one cycle
//   valid_out    : Instr_out is non-zero
//   hazard       : single-cycle flag aligned with the offending Instr_out
//   hazard_reg   : offending source register (rs1 preferred), 0 if no hazard
//   hazard_dist  : distance to the nearest conflicting writer, 0 if no hazard
//   issue_count  : saturating count of non-zero words
//   bubble_count : saturating count of zero words
//   hazard_count : saturating count of flagged hazards
module esm_hazard_checker #(
  parameter int Instruction_word_size = 32,
  parameter int DEPTH                 = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [Instruction_word_size-1:0] Instr_in,
  output logic [Instruction_word_size-1:0] Instr_out,
  output logic                             valid_out,
  output logic                             hazard,
  output logic [4:0]                       hazard_reg,
  output logic [3:0]                       hazard_dist,
  output logic [15:0]                      issue_count,
  output logic [15:0]                      bubble_count,
  output logic [15:0]                      hazard_count
);

  // ---------------------------------------------------------------- decode
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       op_writes;
  logic       op_reads_rs1;
  logic       op_reads_rs2;
  logic       is_writer;
  logic       src1_active;
  logic       src2_active;

  always_comb begin
    opcode       = Instr_in[6:0];
    rd           = Instr_in[11:7];
    rs1          = Instr_in[19:15];
    rs2          = Instr_in[24:20];
    op_writes    = 1'b0;
    op_reads_rs1 = 1'b0;
    op_reads_rs2 = 1'b0;
    case (opcode)
      7'b0110011: begin op_writes = 1'b1; op_reads_rs1 = 1'b1; op_reads_rs2 = 1'b1; end
      7'b0010011: begin op_writes = 1'b1; op_reads_rs1 = 1'b1; end
      7'b0000011: begin op_writes = 1'b1; op_reads_rs1 = 1'b1; end
      7'b0110111: op_writes = 1'b1;
      7'b0010111: op_writes = 1'b1;
      7'b1101111: op_writes = 1'b1;
      7'b1100111: begin op_writes = 1'b1; op_reads_rs1 = 1'b1; end
      7'b0100011: begin op_reads_rs1 = 1'b1; op_reads_rs2 = 1'b1; end
      7'b1100011: begin op_reads_rs1 = 1'b1; op_reads_rs2 = 1'b1; end
      default: ;  // bubbles and unknown opcodes neither read nor write
    endcase
    // x0 is hard-wired: writing it produces nothing, reading it never depends
    is_writer   = op_writes && (rd != 5'd0);
    src1_active = op_reads_rs1 && (rs1 != 5'd0);
    src2_active = op_reads_rs2 && (rs2 != 5'd0);
  end

  // ---------------------------------------------------------------- window
  // Index i holds the word accepted i+1 cycles ago. The comparison below sees
  // the pre-shift contents, so a word never matches its own rd.
  logic       win_wvalid_reg [DEPTH];
  logic [4:0] win_rd_reg     [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        win_wvalid_reg[i] <= 1'b0;
        win_rd_reg[i]     <= 5'd0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        win_wvalid_reg[i] <= win_wvalid_reg[i-1];
        win_rd_reg[i]     <= win_rd_reg[i-1];
      end
      win_wvalid_reg[0] <= is_writer;
      win_rd_reg[0]     <= rd;
    end
  end

  // ---------------------------------------------------------------- match
  logic [DEPTH-1:0] match_rs1;
  logic [DEPTH-1:0] match_rs2;
  logic [DEPTH-1:0] match_any;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match_rs1[gi] = src1_active && win_wvalid_reg[gi] && (win_rd_reg[gi] == rs1);
      assign match_rs2[gi] = src2_active && win_wvalid_reg[gi] && (win_rd_reg[gi] == rs2);
      assign match_any[gi] = match_rs1[gi] || match_rs2[gi];
    end
  endgenerate

  logic       hazard_next;
  logic [4:0] hazard_reg_next;
  logic [3:0] hazard_dist_next;

  always_comb begin
    hazard_next      = |match_any;
    hazard_reg_next  = 5'd0;
    hazard_dist_next = 4'd0;
    // rs1 wins the register report even when rs2 has the nearer writer;
    // the distance is still the nearest match over both sources.
    if (|match_rs1) begin
      hazard_reg_next = rs1;
    end else if (|match_rs2) begin
      hazard_reg_next = rs2;
    end
    // Scan oldest to newest so the nearest match is the last assignment.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match_any[k]) begin
        hazard_dist_next = 4'(k + 1);
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  logic [Instruction_word_size-1:0] instr_out_reg;
  logic                             valid_out_reg;
  logic                             hazard_flag_reg;
  logic [4:0]                       hazard_reg_reg;
  logic [3:0]                       hazard_dist_reg;
  logic [15:0]                      issue_count_reg;
  logic [15:0]                      bubble_count_reg;
  logic [15:0]                      hazard_count_reg;
  logic                             word_nonzero;

  assign word_nonzero = |Instr_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_out_reg    <= '0;
      valid_out_reg    <= 1'b0;
      hazard_flag_reg  <= 1'b0;
      hazard_reg_reg   <= 5'd0;
      hazard_dist_reg  <= 4'd0;
      issue_count_reg  <= 16'd0;
      bubble_count_reg <= 16'd0;
      hazard_count_reg <= 16'd0;
    end else begin
      instr_out_reg   <= Instr_in;
      valid_out_reg   <= word_nonzero;
      hazard_flag_reg <= hazard_next;
      hazard_reg_reg  <= hazard_reg_next;
      hazard_dist_reg <= hazard_dist_next;
      // Counters stick at all-ones instead of wrapping.
      if (word_nonzero && (issue_count_reg != 16'hFFFF)) begin
        issue_count_reg <= issue_count_reg + 16'd1;
      end
      if (!word_nonzero && (bubble_count_reg != 16'hFFFF)) begin
        bubble_count_reg <= bubble_count_reg + 16'd1;
      end
      if (hazard_next && (hazard_count_reg != 16'hFFFF)) begin
        hazard_count_reg <= hazard_count_reg + 16'd1;
      end
    end
  end

  assign Instr_out    = instr_out_reg;
  assign valid_out    = valid_out_reg;
  assign hazard       = hazard_flag_reg;
  assign hazard_reg   = hazard_reg_reg;
  assign hazard_dist  = hazard_dist_reg;
  assign issue_count  = issue_count_reg;
  assign bubble_count = bubble_count_reg;
  assign hazard_count = hazard_count_reg;

endmodule
